// File: rtl/mem_stage_sram.sv
// Memory stage: splits each 32-bit load/store into two 16-bit SRAM accesses
// and holds the rest of the pipeline with freeze while the access is in flight.
module mem_stage_sram #(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic [3:0]  dest_in,
   input  logic [31:0] alu_res_in,
   input  logic [31:0] val_Rm_in,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic [3:0]  dest_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] mem_data_out,
   output logic        freeze,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WORD_W = 17;
   localparam int unsigned HALF_W = 16;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [17:0]        addr_nxt;
   logic [HALF_W-1:0]  dq_nxt;
   logic               oe_nxt;
   logic               we_n_nxt;
   logic [31:0]        data_nxt;

   logic               req;
   logic               is_write;
   logic               is_read;
   logic [WORD_W-1:0]  word;

   assign req      = mem_r_en_in | mem_w_en_in;
   assign is_write = mem_w_en_in;
   assign is_read  = mem_r_en_in & ~mem_w_en_in;
   assign word     = WORD_W'((alu_res_in - 32'(BASE_ADDR)) >> 2);

   // Non-memory fields pass straight through with no added latency
   assign wb_en_out    = wb_en_in;
   assign mem_r_en_out = mem_r_en_in;
   assign dest_out     = dest_in;
   assign alu_res_out  = alu_res_in;

   // Stall everything upstream until the access reaches DONE
   assign freeze = req & (state != S_DONE) & ~rst;

   // Next-state and next SRAM/load-data values
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = sram_addr;
      dq_nxt    = sram_dq_out;
      oe_nxt    = sram_dq_oe;
      we_n_nxt  = sram_we_n;
      data_nxt  = mem_data_out;
      case (state)
         S_IDLE: begin
            if (req) begin
               state_nxt = S_LO;
               addr_nxt  = {word, 1'b0};
               cnt_nxt   = CNT_LOAD;
               if (is_write) begin
                  dq_nxt   = val_Rm_in[15:0];
                  we_n_nxt = 1'b0;
                  oe_nxt   = 1'b1;
               end
            end
         end
         S_LO: begin
            if (cnt == '0) begin
               if (is_read) data_nxt[15:0] = sram_dq_in;
               addr_nxt  = {word, 1'b1};
               dq_nxt    = val_Rm_in[31:16];
               cnt_nxt   = CNT_LOAD;
               state_nxt = S_HI;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_HI: begin
            if (cnt == '0) begin
               if (is_read) data_nxt[31:16] = sram_dq_in;
               we_n_nxt  = 1'b1;
               oe_nxt    = 1'b0;
               state_nxt = S_DONE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counter and SRAM-facing registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         sram_addr    <= '0;
         sram_dq_out  <= '0;
         sram_dq_oe   <= 1'b0;
         sram_we_n    <= 1'b1;
         mem_data_out <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         sram_addr    <= addr_nxt;
         sram_dq_out  <= dq_nxt;
         sram_dq_oe   <= oe_nxt;
         sram_we_n    <= we_n_nxt;
         mem_data_out <= data_nxt;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: SRAM device model, transaction-level reference
// and a per-cycle compare process, plus directed literal checks.
module tb_mem_stage_sram;

   localparam int unsigned W    = 3;
   localparam int unsigned BASE = 1024;

   logic        clk;
   logic        rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [3:0]  dest_in;
   logic [31:0] alu_res_in, val_Rm_in;
   logic        wb_en_out, mem_r_en_out;
   logic [3:0]  dest_out;
   logic [31:0] alu_res_out, mem_data_out;
   logic        freeze;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   mem_stage_sram #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .dest_in(dest_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .dest_out(dest_out),
      .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .freeze(freeze),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   // SRAM device: asynchronous read, write on every clock with we_n low
   bit [15:0] sram_mem [0:262143];
   bit [15:0] ref_mem  [0:262143];
   assign sram_dq_in = sram_mem[sram_addr];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected outputs for the current cycle
   logic [17:0] exp_addr;
   logic [15:0] exp_dq;
   logic        exp_oe, exp_we_n, exp_freeze, exp_wb, exp_mr;
   logic [3:0]  exp_dest;
   logic [31:0] exp_alu, exp_mem;
   bit          chk_en;
   int          n_tests, n_fail, frz_cnt, frz_base, wl_base;
   logic [33:0] wlog [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("freeze",       64'(freeze),       64'(exp_freeze));
            chk("wb_en_out",    64'(wb_en_out),    64'(exp_wb));
            chk("mem_r_en_out", 64'(mem_r_en_out), 64'(exp_mr));
            chk("dest_out",     64'(dest_out),     64'(exp_dest));
            chk("alu_res_out",  64'(alu_res_out),  64'(exp_alu));
            chk("sram_addr",    64'(sram_addr),    64'(exp_addr));
            chk("sram_dq_out",  64'(sram_dq_out),  64'(exp_dq));
            chk("sram_dq_oe",   64'(sram_dq_oe),   64'(exp_oe));
            chk("sram_we_n",    64'(sram_we_n),    64'(exp_we_n));
            chk("mem_data_out", 64'(mem_data_out), 64'(exp_mem));
            if (freeze === 1'b1) frz_cnt++;
            if (sram_we_n === 1'b0) wlog.push_back({sram_addr, sram_dq_out});
         end
      end
   endtask

   // Present one instruction and follow it for its whole stay in the stage.
   // Phase p counts cycles since the instruction arrived; rst_at >= 0 asserts
   // reset at that phase for two cycles, then the held request restarts.
   task automatic run_instr(input logic wb, input logic rd, input logic wr,
                            input logic [3:0] d, input logic [31:0] alu,
                            input logic [31:0] rm, input int rst_at);
      logic        req, is_wr, is_rd;
      logic [16:0] word;
      int          len, p, ra;
      req   = rd | wr;
      is_wr = wr;
      is_rd = rd & ~wr;
      word  = 17'((alu - 32'(BASE)) >> 2);
      len   = req ? int'(2*W + 2) : 1;
      wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
      dest_in = d; alu_res_in = alu; val_Rm_in = rm;
      exp_wb = wb; exp_mr = rd; exp_dest = d; exp_alu = alu;
      ra = rst_at;
      p  = 0;
      while (p < len) begin
         if (p == 1) begin
            exp_addr = {word, 1'b0};
            if (is_wr) begin
               exp_dq = rm[15:0]; exp_we_n = 1'b0; exp_oe = 1'b1;
            end
         end
         if (p == int'(W) + 1) begin
            exp_addr = {word, 1'b1};
            exp_dq   = rm[31:16];
            if (is_rd) exp_mem[15:0] = ref_mem[{word, 1'b0}];
         end
         if (p == int'(2*W) + 1) begin
            exp_we_n = 1'b1; exp_oe = 1'b0;
            if (is_rd) exp_mem[31:16] = ref_mem[{word, 1'b1}];
            if (is_wr) begin
               ref_mem[{word, 1'b0}] = rm[15:0];
               ref_mem[{word, 1'b1}] = rm[31:16];
            end
         end
         exp_freeze = req && (p <= int'(2*W));
         if (p == ra) begin
            rst = 1'b1;
            exp_freeze = 1'b0;
            @(posedge clk); #1;
            exp_addr = '0; exp_dq = '0; exp_oe = 1'b0; exp_we_n = 1'b1;
            exp_mem = '0; exp_freeze = 1'b0;
            #3;
            chk("rst_mid_mem_data", 64'(mem_data_out), 64'h0);
            chk("rst_mid_we_n",     64'(sram_we_n),    64'h1);
            chk("rst_mid_freeze",   64'(freeze),       64'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            ra = -1;
            p  = 0;
            frz_base = frz_cnt;
            continue;
         end
         @(posedge clk); #1;
         p++;
      end
   endtask

   logic [31:0] r_alu;
   int          r_k;
   logic        r_rd, r_wr;

   initial begin
      rst = 1'b1;
      wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
      dest_in = '0; alu_res_in = '0; val_Rm_in = '0;
      exp_addr = '0; exp_dq = '0; exp_oe = 1'b0; exp_we_n = 1'b1;
      exp_freeze = 1'b0; exp_wb = 1'b0; exp_mr = 1'b0; exp_dest = '0;
      exp_alu = '0; exp_mem = '0;
      chk_en = 1'b0; n_tests = 0; n_fail = 0; frz_cnt = 0; frz_base = 0; wl_base = 0;
      for (int i = 0; i < 128; i++) begin
         sram_mem[i] = 16'($urandom);
         ref_mem[i]  = sram_mem[i];
      end
      sram_mem[4] = 16'h1234; ref_mem[4] = 16'h1234;
      sram_mem[5] = 16'hABCD; ref_mem[5] = 16'hABCD;
      fork
         compare_loop();
      join_none

      // Reset state
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Non-memory pass-through
      frz_base = frz_cnt; wl_base = wlog.size();
      run_instr(1'b1, 1'b0, 1'b0, 4'h3, 32'h55, 32'h0, -1);
      chk("pt_freeze_cycles", 64'(frz_cnt - frz_base), 64'd0);
      chk("pt_no_write",      64'(wlog.size() - wl_base), 64'd0);

      // Load of preloaded half-words
      frz_base = frz_cnt;
      run_instr(1'b1, 1'b1, 1'b0, 4'h1, 32'd1032, 32'h0, -1);
      chk("load_freeze_cycles", 64'(frz_cnt - frz_base), 64'd7);
      chk("load_data",          64'(mem_data_out), 64'hABCD1234);

      // Store with two W-cycle strobe windows
      frz_base = frz_cnt; wl_base = wlog.size();
      run_instr(1'b0, 1'b0, 1'b1, 4'h2, 32'd1032, 32'hDEADBEEF, -1);
      chk("store_freeze_cycles", 64'(frz_cnt - frz_base), 64'd7);
      chk("store_we_cycles",     64'(wlog.size() - wl_base), 64'd6);
      for (int i = 0; i < 6; i++)
         if (wl_base + i < wlog.size())
            chk("store_bus", 64'(wlog[wl_base + i]),
                (i < 3) ? {30'd0, 18'd4, 16'hBEEF} : {30'd0, 18'd5, 16'hDEAD});

      // Back-to-back store then load, same address
      frz_base = frz_cnt;
      run_instr(1'b0, 1'b0, 1'b1, 4'h4, 32'd1040, 32'h0BADF00D, -1);
      run_instr(1'b1, 1'b1, 1'b0, 4'h5, 32'd1040, 32'h0, -1);
      chk("b2b_freeze_cycles", 64'(frz_cnt - frz_base), 64'd14);
      chk("b2b_data",          64'(mem_data_out), 64'h0BADF00D);

      // Wrap below BASE with both enables set: performed as a write
      wl_base = wlog.size();
      run_instr(1'b0, 1'b1, 1'b1, 4'h6, 32'd1020, 32'hCAFEF00D, -1);
      chk("wrap_we_cycles", 64'(wlog.size() - wl_base), 64'd6);
      if (wl_base + 5 < wlog.size()) begin
         chk("wrap_lo", 64'(wlog[wl_base]),     {30'd0, 18'h3FFFE, 16'hF00D});
         chk("wrap_hi", 64'(wlog[wl_base + 5]), {30'd0, 18'h3FFFF, 16'hCAFE});
      end
      run_instr(1'b1, 1'b1, 1'b0, 4'h7, 32'd1020, 32'h0, -1);
      chk("wrap_load", 64'(mem_data_out), 64'hCAFEF00D);

      // Reset during the HI half of a load, request held across it
      run_instr(1'b1, 1'b1, 1'b0, 4'h8, 32'd1032, 32'h0, int'(W) + 2);
      chk("rst_restart_freeze_cycles", 64'(frz_cnt - frz_base), 64'd7);
      chk("rst_restart_data",          64'(mem_data_out), 64'hDEADBEEF);

      // Randomized mix of loads, stores and plain instructions
      for (int i = 0; i < 300; i++) begin
         r_k  = int'($urandom_range(0, 9));
         r_rd = (r_k >= 4 && r_k <= 6) || r_k == 9;
         r_wr = (r_k >= 7);
         if ($urandom_range(0, 7) == 0) r_alu = $urandom;
         else r_alu = 32'(BASE) + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
         run_instr(1'($urandom), r_rd, r_wr, 4'($urandom), r_alu, $urandom, -1);
      end

      run_instr(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, -1);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
